// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg
//   Shared definitions for the CPU clock controller: FSM state encoding,
//   cycle counter width and the divider counter width helper.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        STEP_WAIT  = 2'd0,
        STEP_PULSE = 2'd1,
        RUN        = 2'd2,
        HALTED     = 2'd3
    } clk_state_e;

    localparam int unsigned COUNT_W = 32;

    // Divider counter must hold 2^(shift+7)-1, the largest half-period minus one.
    function automatic int unsigned div_cnt_width(input int unsigned shift);
        return shift + 8;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_key_debounce.sv
// key_debounce
//   Two-flop synchronizer followed by a debounce counter for one raw input.
//   Ports:
//     clk, rst    board clock, synchronous active-high reset
//     key_raw     asynchronous, possibly bouncy input
//     key_stable  debounced level (resets to RESET_LEVEL)
//     key_fall    one-cycle pulse when key_stable goes 1->0
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_stable,
    output logic key_fall
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = key_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        fall_d   = 1'b0;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            // DEBOUNCE_CYCLES consecutive differing samples: accept the new level
            stable_d = sync2_q;
            fall_d   = ~sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
        end
    end

    assign key_stable = stable_q;
    assign key_fall   = fall_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
//   Derives the CPU clock from the board clock: debounced single-step,
//   free-run at 2^(DIV_SHIFT_MIN+div_sel) half-period, or permanent halt.
//   Ports:
//     clk, rst     board clock, synchronous active-high reset
//     step_n       raw active-low step pushbutton
//     run          raw run/step switch (1 = free-run)
//     div_sel      free-run rate select, latched at reset and toggle points
//     halt         CPU request to stop the clock
//     cpu_clk      registered CPU clock
//     cpu_rise     one-cycle pulse coincident with cpu_clk going high
//     cycle_count  number of cpu_clk rising edges since reset
//     state        FSM state for LEDs
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned DIV_SHIFT_MIN   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_n,
    input  logic               run,
    input  logic [2:0]         div_sel,
    input  logic               halt,
    output logic               cpu_clk,
    output logic               cpu_rise,
    output logic [COUNT_W-1:0] cycle_count,
    output logic [1:0]         state
);

    localparam int unsigned DIV_W = div_cnt_width(DIV_SHIFT_MIN);

    logic step_stable_unused;
    logic step_fall;
    logic run_stable;
    logic run_fall_unused;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b1)
    ) u_step_db (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (step_n),
        .key_stable(step_stable_unused),
        .key_fall  (step_fall)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b0)
    ) u_run_db (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (run),
        .key_stable(run_stable),
        .key_fall  (run_fall_unused)
    );

    clk_state_e         state_q, state_d;
    logic               cpu_clk_q, cpu_clk_d;
    logic               cpu_rise_q, cpu_rise_d;
    logic [COUNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [2:0]         div_lat_q, div_lat_d;
    logic [DIV_W-1:0]   hp_m1;
    logic               phase_done;

    always_comb begin
        hp_m1      = (DIV_W'(1) << (DIV_SHIFT_MIN + 32'(div_lat_q))) - DIV_W'(1);
        phase_done = (div_cnt_q >= hp_m1);
    end

    always_comb begin
        state_d       = state_q;
        cpu_clk_d     = cpu_clk_q;
        cpu_rise_d    = 1'b0;
        cycle_count_d = cycle_count_q;
        div_cnt_d     = div_cnt_q;
        div_lat_d     = div_lat_q;
        case (state_q)
            STEP_WAIT: begin
                cpu_clk_d = 1'b0;
                if (halt) begin
                    state_d = HALTED;
                end else if (run_stable) begin
                    state_d   = RUN;
                    div_cnt_d = '0;
                end else if (step_fall) begin
                    state_d       = STEP_PULSE;
                    cpu_clk_d     = 1'b1;
                    cpu_rise_d    = 1'b1;
                    cycle_count_d = cycle_count_q + COUNT_W'(1);
                    div_cnt_d     = '0;
                end
            end
            STEP_PULSE: begin
                // Step falls arriving here are not remembered: STEP_WAIT only
                // reacts to the one-cycle fall pulse.
                if (phase_done) begin
                    cpu_clk_d = 1'b0;
                    div_cnt_d = '0;
                    state_d   = STEP_WAIT;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            RUN: begin
                if (phase_done) begin
                    div_cnt_d = '0;
                    div_lat_d = div_sel;
                    // Mode changes only at the end of a low phase, so every
                    // phase lasts a full half-period.
                    if (cpu_clk_q) begin
                        cpu_clk_d = 1'b0;
                    end else if (halt) begin
                        state_d = HALTED;
                    end else if (!run_stable) begin
                        state_d = STEP_WAIT;
                    end else begin
                        cpu_clk_d     = 1'b1;
                        cpu_rise_d    = 1'b1;
                        cycle_count_d = cycle_count_q + COUNT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            HALTED: begin
                cpu_clk_d = 1'b0;
            end
            default: begin
                state_d = STEP_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= STEP_WAIT;
            cpu_clk_q     <= 1'b0;
            cpu_rise_q    <= 1'b0;
            cycle_count_q <= '0;
            div_cnt_q     <= '0;
            div_lat_q     <= div_sel;
        end else begin
            state_q       <= state_d;
            cpu_clk_q     <= cpu_clk_d;
            cpu_rise_q    <= cpu_rise_d;
            cycle_count_q <= cycle_count_d;
            div_cnt_q     <= div_cnt_d;
            div_lat_q     <= div_lat_d;
        end
    end

    assign cpu_clk     = cpu_clk_q;
    assign cpu_rise    = cpu_rise_q;
    assign cycle_count = cycle_count_q;
    assign state       = state_q;

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Upstream of the processor on the FPGA board. Replaces the bare free-running divider that currently feeds the CPU clock.
- Derives the CPU clock from the 10 MHz board clock. Three modes: debounced single-step, free-run at a switch-selected rate, and permanent halt on CPU request.
- Counts CPU clock rising edges for LED/HEX debug display.

Parameters:
DEBOUNCE_CYCLES, 100000, board-clock cycles an input must hold steady before it is accepted (10 ms at 10 MHz)
DIV_SHIFT_MIN, 16, free-run half-period = 2^(DIV_SHIFT_MIN + div_sel) board cycles

Ports:
clk  in  1  board clock (CLOCK_ADC_10 domain); the only clock
rst  in  1  reset, synchronous, active-high
step_n  in  1  raw pushbutton, active-low, asynchronous, bouncy
run  in  1  raw switch, asynchronous: 1 = free-run, 0 = single-step
div_sel  in  3  free-run rate select, quasi-static
halt  in  1  synchronous level from CPU; request to stop the clock
cpu_clk  out  1  registered CPU clock
cpu_rise  out  1  one-cycle pulse, high in the same cycle cpu_clk goes 0->1
cycle_count  out  32  number of cpu_clk rising edges since reset
state  out  2  FSM state, for LEDs

Behaviour:
- Reset, next clk edge: cpu_clk=0, cpu_rise=0, cycle_count=0, state=STEP_WAIT, divider counter=0.
- Debounce and synchronizer state clears to the idle level: step_n stable=1, run stable=0.
- step_n and run each pass through a 2-flop synchronizer and then a debouncer.
- Debouncer: counter restarts whenever the synced value equals the stable value. The stable value updates after DEBOUNCE_CYCLES consecutive cycles of the synced value differing from it.
- Step event = stable step_n falling 1->0. Fixed latency: raw fall to cpu_rise = DEBOUNCE_CYCLES+3 cycles.
- hp = 2^(DIV_SHIFT_MIN + div_sel_latched). div_sel is latched at reset and at every toggle point.
- State encoding: STEP_WAIT=0, STEP_PULSE=1, RUN=2, HALTED=3.
- STEP_WAIT (cpu_clk=0); priority halt > run > step:
  - halt -> HALTED.
  - else run stable=1 -> RUN, counter=0.
  - else step event -> STEP_PULSE, with cpu_clk<=1, cpu_rise=1, cycle_count+1.
- STEP_PULSE: cpu_clk held 1 for exactly hp cycles, then cpu_clk<=0 and state -> STEP_WAIT. Step events arriving during the pulse are dropped, not queued.
- RUN: counter increments each cycle. When counter >= hp-1: counter<=0 and a toggle point occurs.
  - cpu_clk 1 at toggle point -> cpu_clk<=0.
  - cpu_clk 0 at toggle point, halt=1 -> HALTED, cpu_clk stays 0.
  - cpu_clk 0 at toggle point, run stable=0 -> STEP_WAIT, cpu_clk stays 0.
  - otherwise -> cpu_clk<=1, cpu_rise=1, cycle_count+1.
  - Consequence: every high and low phase of cpu_clk lasts a full hp, so no runt pulses.
- HALTED: cpu_clk=0, no pulses, count frozen. Only rst exits.
- halt asserted mid-pulse: the pulse completes, then STEP_WAIT, then HALTED on the next cycle.
- cycle_count wraps from 2^32-1 to 0.
- rst mid-operation (including cpu_clk high): cpu_clk=0 on the next edge. This short high phase is accepted.
- cpu_clk comes only from a flop, never from combinational logic.

Decomposition:
- Package cpu_clk_pkg:
  - state encodings STEP_WAIT/STEP_PULSE/RUN/HALTED
  - COUNT_W=32
  - divider counter width = DIV_SHIFT_MIN+8
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES, RESET_LEVEL): 2-flop sync plus debounce counter; outputs stable level and one-cycle fall pulse.
  - Instantiated twice: step_n (RESET_LEVEL=1), run (RESET_LEVEL=0).

Test Plan (bench uses DEBOUNCE_CYCLES=4, DIV_SHIFT_MIN=2):
- Reset: rst=1 for 2 cycles, run=0 -> cpu_clk=0, cpu_rise=0, cycle_count=0, state=0.
- Clean step: step_n low 12 cycles then high, div_sel=0 -> one cpu_rise 7 cycles after the fall; cpu_clk high exactly 4 cycles; cycle_count=1; state back to 0.
- Bounce: step_n toggles every 2 cycles for 12 cycles, then held low 12 -> exactly one cpu_rise; cycle_count=1.
- Free-run: run=1, div_sel=1 (hp=8) -> cpu_rise every 16 cycles, duty 8/8; after 10 rises cycle_count=10; state=2.
- Halt in RUN: halt=1 while cpu_clk high -> high phase finishes (8 cycles), low phase lasts 8, state=3; no further cpu_rise for 100 cycles; count frozen; run toggles ignored.
- Reset mid-run: rst=1 while cpu_clk=1 -> next edge cpu_clk=0, cycle_count=0, state=0; after rst drops with run=1, first cpu_rise occurs after the debounce latency plus one low phase.
